la_capture_sequencer: RTL

- Control-plane sequencer for the 8-channel logic-analyzer capture counter; sits between the PIC command interface and the counter.
- Serially loads the counter's 29-bit setup word: trigger value, trigger mask, sample count.
- Pulses run, waits for capture completion, then paces SRAM readout by driving the counter's mode_setup/mode_run/mode_read/mode_clock inputs.
- Runs entirely on osc_clock; the counter's done is resynchronised.

---
 rtl/la_capture_sequencer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/la_capture_sequencer.sv
// la_capture_sequencer: control-plane sequencer for the 8-channel logic-analyzer
// capture counter. Shifts the 29-bit setup word, pulses run, waits for the
// resynchronised done, then paces SRAM readout. Everything runs on osc_clock.
module la_capture_sequencer #(
  parameter int unsigned RUN_CYCLES  = 2,
  parameter int unsigned READ_DEPTH  = 32768,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        osc_clock,
  input  logic        reset,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [7:0]  cfg_trigger_value,
  input  logic [7:0]  cfg_trigger_mask,
  input  logic [12:0] cfg_sample_count,
  input  logic [3:0]  cfg_clock_sel,
  input  logic        arm,
  input  logic        abort,
  input  logic        rd_ready,
  input  logic        done,
  output logic        mode_setup,
  output logic        mode_run,
  output logic        mode_read,
  output logic [3:0]  mode_clock,
  output logic        rd_strobe,
  output logic        busy,
  output logic        cfg_loaded,
  output logic        captured,
  output logic [2:0]  state
);

  localparam int unsigned RUN_W    = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_CYCLES - 1);
  localparam logic [15:0] DEPTH    = 16'(READ_DEPTH);
  localparam logic [3:0]  CLK_OSC  = 4'b0010;
  localparam logic [4:0]  LAST_BIT = 5'd28;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    RUN       = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4,
    READ      = 3'd5
  } state_t;

  state_t                 st_q;
  logic [SYNC_STAGES-1:0] done_sync;
  logic                   done_s;
  logic [27:0]            shift_q;   // remaining setup bits; S[28] goes out directly
  logic [3:0]             sel_q;
  logic [4:0]             bit_cnt;
  logic [15:0]            word_cnt;
  logic [RUN_W-1:0]       run_cnt;

  assign done_s = done_sync[SYNC_STAGES-1];
  assign state  = st_q;

  // Resynchronise the counter's done into osc_clock
  always_ff @(posedge osc_clock or posedge reset) begin
    if (reset) done_sync <= '0;
    else       done_sync <= {done_sync[SYNC_STAGES-2:0], done};
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge osc_clock or posedge reset) begin
    if (reset) begin
      st_q       <= IDLE;
      mode_setup <= 1'b0;
      mode_run   <= 1'b0;
      mode_read  <= 1'b0;
      mode_clock <= CLK_OSC;
      rd_strobe  <= 1'b0;
      busy       <= 1'b0;
      cfg_ready  <= 1'b1;
      cfg_loaded <= 1'b0;
      captured   <= 1'b0;
      shift_q    <= '0;
      sel_q      <= CLK_OSC;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      run_cnt    <= '0;
    end else if (abort) begin
      if (st_q == LOAD) cfg_loaded <= 1'b0;
      st_q       <= IDLE;
      mode_setup <= 1'b0;
      mode_run   <= 1'b0;
      mode_read  <= 1'b0;
      mode_clock <= CLK_OSC;
      rd_strobe  <= 1'b0;
      busy       <= 1'b0;
      cfg_ready  <= 1'b1;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      run_cnt    <= '0;
    end else begin
      rd_strobe <= 1'b0;
      case (st_q)
        IDLE: begin
          if (cfg_valid) begin
            // cfg_valid wins over a simultaneous arm
            st_q       <= LOAD;
            shift_q    <= {cfg_sample_count[11:0], cfg_trigger_mask, cfg_trigger_value};
            sel_q      <= cfg_clock_sel;
            mode_setup <= 1'b1;
            mode_read  <= cfg_sample_count[12];
            bit_cnt    <= '0;
            cfg_loaded <= 1'b0;
            busy       <= 1'b1;
            cfg_ready  <= 1'b0;
          end else if (arm && cfg_loaded) begin
            st_q      <= RUN;
            mode_run  <= 1'b1;
            run_cnt   <= '0;
            captured  <= 1'b0;
            busy      <= 1'b1;
            cfg_ready <= 1'b0;
          end
        end
        LOAD: begin
          if (bit_cnt == LAST_BIT) begin
            st_q       <= IDLE;
            mode_setup <= 1'b0;
            mode_read  <= 1'b0;
            cfg_loaded <= 1'b1;
            busy       <= 1'b0;
            cfg_ready  <= 1'b1;
          end else begin
            bit_cnt   <= bit_cnt + 5'd1;
            mode_read <= shift_q[27];
            shift_q   <= {shift_q[26:0], 1'b0};
          end
        end
        RUN: begin
          if (run_cnt == RUN_LAST) begin
            st_q       <= WAIT_BUSY;
            mode_run   <= 1'b0;
            mode_clock <= sel_q;
          end else begin
            run_cnt <= run_cnt + RUN_W'(1);
          end
        end
        WAIT_BUSY: begin
          // a done still high from the previous capture is not completion
          if (!done_s) st_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (done_s) begin
            st_q       <= READ;
            captured   <= 1'b1;
            mode_clock <= CLK_OSC;
            word_cnt   <= DEPTH;
          end
        end
        READ: begin
          if (word_cnt == 16'd0) begin
            st_q      <= IDLE;
            mode_read <= 1'b0;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
          end else if (rd_ready) begin
            mode_read <= 1'b1;
            rd_strobe <= 1'b1;
            word_cnt  <= word_cnt - 16'd1;
          end else begin
            mode_read <= 1'b0;
          end
        end
        default: begin
          st_q       <= IDLE;
          mode_setup <= 1'b0;
          mode_run   <= 1'b0;
          mode_read  <= 1'b0;
          mode_clock <= CLK_OSC;
          busy       <= 1'b0;
          cfg_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
